// File: rtl/scan_chain_ctrl.sv
// Mux-D scan chain of WIDTH cells with a self-timed WIDTH-cycle shift sequencer.
// Optional shadow update register `upd` is built when SCAN_UPDATE_EN is defined.
module scan_chain_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             cap_en,
    input  logic             si,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic             se,
    output logic             busy,
    output logic             done
`ifdef SCAN_UPDATE_EN
    ,
    output logic [WIDTH-1:0] upd
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] q_nxt;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                end else if (cap_en) begin
                    q_nxt = d;
                end
            end
            SHIFT: begin
                // Shift-left form also covers WIDTH=1, where it reduces to q <= si.
                q_nxt = (q << 1) | WIDTH'(si);
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            q     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Status flags are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            se   <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            se   <= (state_nxt == SHIFT);
            busy <= (state_nxt != IDLE);
            done <= (state_nxt == DONE);
        end
    end

`ifdef SCAN_UPDATE_EN
    // Loads together with the final shift so functional logic never sees partial data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd <= '0;
        end else if (state == SHIFT && state_nxt == DONE) begin
            upd <= q_nxt;
        end
    end
`endif

    assign so = q[WIDTH-1];

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl: table-driven capture/shift vectors plus
// hand sequences for priority, mid-shift reset and the WIDTH=1 chain.
module tb_scan_chain_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] d;
    logic       cap_en, si, start;
    logic [7:0] q;
    logic       so, se, busy, done;

    logic       d1, cap_en1, si1, start1;
    logic       q1, so1, se1, busy1, done1;

`ifdef SCAN_UPDATE_EN
    logic [7:0] upd;
    logic       upd1;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    scan_chain_ctrl #(.WIDTH(8), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .d(d), .cap_en(cap_en), .si(si), .start(start),
        .q(q), .so(so), .se(se), .busy(busy), .done(done)
`ifdef SCAN_UPDATE_EN
        , .upd(upd)
`endif
    );

    scan_chain_ctrl #(.WIDTH(1), .CNT_W(1)) dut1 (
        .clk(clk), .reset(reset), .d(d1), .cap_en(cap_en1), .si(si1), .start(start1),
        .q(q1), .so(so1), .se(se1), .busy(busy1), .done(done1)
`ifdef SCAN_UPDATE_EN
        , .upd(upd1)
`endif
    );

    typedef struct {
        logic       start;
        logic       cap_en;
        logic       si;
        logic [7:0] d;
        logic [7:0] exp_q;
        logic       exp_so;
        logic       exp_se;
        logic       exp_busy;
        logic       exp_done;
        logic [7:0] exp_upd;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic c, input logic i, input logic [7:0] dv);
        start  = s;
        cap_en = c;
        si     = i;
        d      = dv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  se_cnt;
        int  done_cnt;
        int  budget;

        //              start cap si  d      q      so se busy done upd
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 1, 0, 0, 0, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hA5, 1, 1, 1, 0, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h4B, 0, 1, 1, 0, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h96, 1, 1, 1, 0, 8'h00};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 8'hFF, 8'h2D, 0, 1, 1, 0, 8'h00};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h5B, 0, 1, 1, 0, 8'h00};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'hB6, 1, 1, 1, 0, 8'h00};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h6C, 0, 1, 1, 0, 8'h00};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hD9, 1, 1, 1, 0, 8'h00};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hB2, 1, 0, 1, 1, 8'hB2};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'hB2, 1, 0, 0, 0, 8'hB2};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hB2, 1, 0, 0, 0, 8'hB2};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C, 0, 0, 0, 0, 8'hB2};

        reset = 1'b0;
        start = 0; cap_en = 0; si = 0; d = '0;
        start1 = 0; cap_en1 = 0; si1 = 0; d1 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_q", 64'(q), 64'h00);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_q", 64'(q), 64'h00);
        check("post_reset_so", 64'(so), 64'h0);
        check("post_reset_se", 64'(se), 64'h0);
        check("post_reset_busy", 64'(busy), 64'h0);
        check("post_reset_done", 64'(done), 64'h0);
`ifdef SCAN_UPDATE_EN
        check("post_reset_upd", 64'(upd), 64'h00);
`endif

        // Capture A5, shift in 1,0,1,1,0,0,1,0 -> B2; start/cap_en toggled while busy.
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].start, vecs[i].cap_en, vecs[i].si, vecs[i].d);
            check($sformatf("vec%0d_q", i), 64'(q), 64'(vecs[i].exp_q));
            check($sformatf("vec%0d_so", i), 64'(so), 64'(vecs[i].exp_so));
            check($sformatf("vec%0d_se", i), 64'(se), 64'(vecs[i].exp_se));
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
            check($sformatf("vec%0d_done", i), 64'(done), 64'(vecs[i].exp_done));
`ifdef SCAN_UPDATE_EN
            check($sformatf("vec%0d_upd", i), 64'(upd), 64'(vecs[i].exp_upd));
`endif
        end

        // Start wins over capture from q=3C; then three shifts of si=1 and an async reset.
        step(1, 1, 0, 8'hFF);
        check("prio_q", 64'(q), 64'h3C);
        check("prio_se", 64'(se), 64'h1);
        step(0, 0, 1, 8'h00);
        check("mid_shift1_q", 64'(q), 64'h79);
        step(0, 0, 1, 8'h00);
        check("mid_shift2_q", 64'(q), 64'hF3);
        step(0, 0, 1, 8'h00);
        check("mid_shift3_q", 64'(q), 64'hE7);
        #2;
        reset = 1'b0;
        #1;
        check("abort_q", 64'(q), 64'h00);
        check("abort_se", 64'(se), 64'h0);
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_done", 64'(done), 64'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("in_reset_done", 64'(done), 64'h0);
        end
        reset = 1'b1;
        repeat (3) begin
            step(0, 0, 0, 8'h00);
            check("after_abort_done", 64'(done), 64'h0);
            check("after_abort_busy", 64'(busy), 64'h0);
        end

        // Fresh full shift after the abort: count se cycles and done pulses.
        step(1, 0, 1, 8'h00);
        se_cnt   = 0;
        done_cnt = 0;
        budget   = 0;
        while (!done && budget < 20) begin
            if (se) se_cnt++;
            step(0, 0, 1, 8'h00);
            budget++;
        end
        check("restart_done_seen", 64'(done), 64'h1);
        check("restart_se_cycles", 64'(se_cnt), 64'd8);
        check("restart_q", 64'(q), 64'hFF);
        for (int i = 0; i < 4; i++) begin
            if (done) done_cnt++;
            step(0, 0, 0, 8'h00);
        end
        check("restart_done_count", 64'(done_cnt), 64'd1);

        // WIDTH=1 chain: one-cycle SHIFT, then DONE.
        check("w1_idle_q", 64'(q1), 64'h0);
        start1 = 1; si1 = 1;
        @(posedge clk);
        #1;
        start1 = 0;
        check("w1_shift_se", 64'(se1), 64'h1);
        check("w1_shift_q", 64'(q1), 64'h0);
        @(posedge clk);
        #1;
        si1 = 0;
        check("w1_done_q", 64'(q1), 64'h1);
        check("w1_done_so", 64'(so1), 64'h1);
        check("w1_done_se", 64'(se1), 64'h0);
        check("w1_done_done", 64'(done1), 64'h1);
        @(posedge clk);
        #1;
        check("w1_idle_done", 64'(done1), 64'h0);
        check("w1_idle_busy", 64'(busy1), 64'h0);
        check("w1_hold_q", 64'(q1), 64'h1);
`ifdef SCAN_UPDATE_EN
        check("w1_upd", 64'(upd1), 64'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
